// File: rtl/muldiv_sched.sv
// Issue sequencer for the shared iterative MUL/DIV unit: latches operands, times the
// fixed unit latency, stalls decode, and short-circuits repeats through a one-entry cache.
module muldiv_sched #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            req_valid,
  input  logic            req_mul,
  input  logic            req_div,
  input  logic [2:0]      req_sel,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            u_start,
  output logic            u_is_div,
  output logic [2:0]      u_sel,
  output logic [XLEN-1:0] u_a,
  output logic [XLEN-1:0] u_b,
  input  logic [XLEN-1:0] u_result,
  output logic            md_stall,
  output logic            md_ready,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic            is_div;
    logic [2:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } tag_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              cache_valid;
  tag_t              cache_tag;
  logic [XLEN-1:0]   cache_result;

  logic              md_class_c;
  logic              is_div_c;
  tag_t              req_tag_c;
  logic              hit_c;
  logic              miss_fire_c;
  logic              hit_fire_c;
  logic              capture_c;

  // MUL wins when both class bits are set.
  assign md_class_c = req_valid & (req_mul | req_div);
  assign is_div_c   = req_div & ~req_mul;
  assign req_tag_c  = '{is_div: is_div_c, sel: req_sel, a: req_rs1, b: req_rs2};
  assign hit_c      = cache_valid && (cache_tag == req_tag_c);

  assign md_stall = md_class_c & (state != DONE);
  assign md_ready = (state == DONE);

  always_ff @(posedge clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_d     = state;
    miss_fire_c = 1'b0;
    hit_fire_c  = 1'b0;
    capture_c   = 1'b0;
    case (state)
      IDLE: begin
        if (md_class_c && !stall_in && !flush) begin
          if (hit_c) begin
            hit_fire_c = 1'b1;
            state_d    = DONE;
          end else begin
            miss_fire_c = 1'b1;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        // The unit cannot be frozen, so stall_in does not hold the count.
        if (flush) begin
          state_d = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (flush || (req_valid && !stall_in)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, latency counter, result capture and cache.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      cnt          <= '0;
      u_start      <= 1'b0;
      u_is_div     <= 1'b0;
      u_sel        <= '0;
      u_a          <= '0;
      u_b          <= '0;
      md_result    <= '0;
      md_rd        <= '0;
      cache_valid  <= 1'b0;
      cache_tag    <= '0;
      cache_result <= '0;
    end else begin
      u_start <= miss_fire_c;
      if (miss_fire_c) begin
        u_is_div <= is_div_c;
        u_sel    <= req_sel;
        u_a      <= req_rs1;
        u_b      <= req_rs2;
        cnt      <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (state == BUSY) begin
        cnt <= flush ? '0 : cnt - CNT_W'(1);
      end
      if (miss_fire_c || hit_fire_c) md_rd <= req_rd;
      if (hit_fire_c) md_result <= cache_result;
      if (capture_c) begin
        md_result    <= u_result;
        cache_result <= u_result;
        cache_valid  <= 1'b1;
        cache_tag    <= '{is_div: u_is_div, sel: u_sel, a: u_a, b: u_b};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with a behavioural fixed-latency MUL/DIV unit.
module tb_muldiv_sched;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 33;

  logic            clk = 1'b0;
  logic            Rst = 1'b0;
  logic            stall_in = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_mul = 1'b0;
  logic            req_div = 1'b0;
  logic [2:0]      req_sel = '0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic [4:0]      req_rd = '0;
  logic            u_start;
  logic            u_is_div;
  logic [2:0]      u_sel;
  logic [XLEN-1:0] u_a;
  logic [XLEN-1:0] u_b;
  logic [XLEN-1:0] u_result;
  logic            md_stall;
  logic            md_ready;
  logic [XLEN-1:0] md_result;
  logic [4:0]      md_rd;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  muldiv_sched #(.XLEN(XLEN), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .Rst(Rst), .stall_in(stall_in), .flush(flush),
    .req_valid(req_valid), .req_mul(req_mul), .req_div(req_div), .req_sel(req_sel),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .u_start(u_start), .u_is_div(u_is_div), .u_sel(u_sel), .u_a(u_a), .u_b(u_b),
    .u_result(u_result), .md_stall(md_stall), .md_ready(md_ready),
    .md_result(md_result), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  // Unit model: result is valid only in the last counted cycle, garbage otherwise.
  int              rem = 0;
  logic [XLEN-1:0] res_m = '0;
  always @(posedge clk) begin
    if (u_start) begin
      rem   <= u_is_div ? int'(DIV_LAT) - 1 : int'(MUL_LAT) - 1;
      res_m <= u_is_div ? u_a / u_b : u_a * u_b;
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end
  assign u_result = (rem == 1) ? res_m : 32'hDEAD_BEEF;

  // Scoreboard: every entry into DONE must match the oldest outstanding expectation.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (md_ready === 1'b1 && prev_ready !== 1'b1) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL sb_unexpected_ready t=%0t result=%0d rd=%0d", $time, md_result, md_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (md_result !== e.res || md_rd !== e.rd) begin
          nerr++;
          $display("FAIL sb_result t=%0t got result=%0d rd=%0d exp result=%0d rd=%0d",
                   $time, md_result, md_rd, e.res, e.rd);
        end
      end
    end
    prev_ready = md_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic m, input logic d, input logic [2:0] s,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] rd);
    req_valid = 1'b1;
    req_mul   = m;
    req_div   = d;
    req_sel   = s;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_mul   = 1'b0;
    req_div   = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (md_ready !== 1'b1 && n < budget) begin
      step();
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    drive_idle();
    step();
    step();
    #1;
    nvec++;
    if ({u_start, u_is_div, u_sel, u_a, u_b, md_ready, md_result, md_rd, md_stall} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got start=%b div=%b sel=%0d a=%0d b=%0d rdy=%b res=%0d rd=%0d stall=%b exp all 0",
               u_start, u_is_div, u_sel, u_a, u_b, md_ready, md_result, md_rd, md_stall);
    end
    Rst = 1'b1;
  endtask

  task automatic test_mul();
    int stalls = 0;
    for (int c = 0; c <= 6; c++) begin
      step();
      if (c == 0) begin
        drive_req(1'b1, 1'b0, 3'd0, 32'd7, 32'd6, 5'd5);
        sb.push_back('{32'd42, 5'd5});
      end
      if (c == 6) drive_idle();
      #1;
      if (md_stall === 1'b1) stalls++;
      nvec++;
      if ({u_start, md_ready} !== {c == 1, c == 5}) begin
        nerr++;
        $display("FAIL mul_timing c=%0d got start=%b ready=%b exp start=%b ready=%b",
                 c, u_start, md_ready, c == 1, c == 5);
      end
      if (c == 1) begin
        nvec++;
        if (u_a !== 32'd7 || u_b !== 32'd6 || u_is_div !== 1'b0) begin
          nerr++;
          $display("FAIL mul_operands got a=%0d b=%0d div=%b exp a=7 b=6 div=0", u_a, u_b, u_is_div);
        end
      end
    end
    nvec++;
    if (stalls != 5) begin
      nerr++;
      $display("FAIL mul_stall_cycles got %0d exp 5", stalls);
    end
  endtask

  task automatic test_cache_hit();
    int n;
    step();
    drive_req(1'b0, 1'b1, 3'd5, 32'd100, 32'd7, 5'd3);
    sb.push_back('{32'd14, 5'd3});
    #1;
    wait_ready(60, n);
    nvec++;
    if (n != int'(DIV_LAT) + 1) begin
      nerr++;
      $display("FAIL div_latency got %0d exp %0d", n, DIV_LAT + 1);
    end
    step();
    drive_req(1'b0, 1'b1, 3'd5, 32'd100, 32'd7, 5'd9);
    sb.push_back('{32'd14, 5'd9});
    #1;
    nvec++;
    if ({md_stall, md_ready} !== 2'b10) begin
      nerr++;
      $display("FAIL hit_accept got stall=%b ready=%b exp stall=1 ready=0", md_stall, md_ready);
    end
    step();
    #1;
    nvec++;
    if ({u_start, md_ready, md_stall} !== 3'b010 || md_result !== 32'd14 || md_rd !== 5'd9) begin
      nerr++;
      $display("FAIL hit_done got start=%b ready=%b stall=%b res=%0d rd=%0d exp 0 1 0 14 9",
               u_start, md_ready, md_stall, md_result, md_rd);
    end
    step();
    drive_idle();
    #1;
    nvec++;
    if (md_ready !== 1'b0) begin
      nerr++;
      $display("FAIL hit_consume got ready=%b exp 0", md_ready);
    end
  endtask

  task automatic test_flush();
    int n;
    step();
    drive_req(1'b0, 1'b1, 3'd5, 32'd200, 32'd9, 5'd4);
    sb.push_back('{32'd22, 5'd4});
    #1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 10) begin
        flush = 1'b1;
        void'(sb.pop_back());
      end
      #1;
      if (c == 1) begin
        nvec++;
        if (u_start !== 1'b1) begin
          nerr++;
          $display("FAIL flush_first_start got %b exp 1", u_start);
        end
      end
    end
    step();
    flush = 1'b0;
    sb.push_back('{32'd22, 5'd4});
    #1;
    nvec++;
    if ({md_ready, md_stall} !== 2'b01) begin
      nerr++;
      $display("FAIL flush_idle got ready=%b stall=%b exp ready=0 stall=1", md_ready, md_stall);
    end
    step();
    #1;
    nvec++;
    if (u_start !== 1'b1) begin
      nerr++;
      $display("FAIL flush_reissue got start=%b exp 1", u_start);
    end
    wait_ready(60, n);
    nvec++;
    if (n != int'(DIV_LAT)) begin
      nerr++;
      $display("FAIL flush_latency got %0d exp %0d", n, DIV_LAT);
    end
    step();
    drive_idle();
    #1;
  endtask

  task automatic test_stall_busy();
    step();
    drive_req(1'b0, 1'b1, 3'd5, 32'd1000, 32'd10, 5'd6);
    sb.push_back('{32'd100, 5'd6});
    #1;
    for (int c = 1; c <= 42; c++) begin
      step();
      stall_in = (c >= 2 && c <= 40);
      if (c == 42) drive_idle();
      #1;
      nvec++;
      if ({u_start, md_ready} !== {c == 1, c >= 34 && c <= 41}) begin
        nerr++;
        $display("FAIL stall_busy c=%0d got start=%b ready=%b exp start=%b ready=%b",
                 c, u_start, md_ready, c == 1, c >= 34 && c <= 41);
      end
    end
  endtask

  task automatic test_reset_busy();
    int n;
    step();
    drive_req(1'b1, 1'b0, 3'd0, 32'd3, 32'd5, 5'd2);
    sb.push_back('{32'd15, 5'd2});
    #1;
    wait_ready(10, n);
    nvec++;
    if (n != int'(MUL_LAT) + 1) begin
      nerr++;
      $display("FAIL prefill_latency got %0d exp %0d", n, MUL_LAT + 1);
    end
    step();
    drive_req(1'b0, 1'b1, 3'd5, 32'd50, 32'd5, 5'd8);
    sb.push_back('{32'd10, 5'd8});
    #1;
    step();
    step();
    step();
    Rst = 1'b0;
    void'(sb.pop_back());
    #1;
    step();
    Rst = 1'b1;
    drive_idle();
    #1;
    nvec++;
    if ({u_start, u_is_div, u_sel, u_a, u_b, md_ready, md_result, md_rd, md_stall} !== '0) begin
      nerr++;
      $display("FAIL rst_busy_outputs got start=%b div=%b sel=%0d a=%0d b=%0d rdy=%b res=%0d rd=%0d stall=%b exp all 0",
               u_start, u_is_div, u_sel, u_a, u_b, md_ready, md_result, md_rd, md_stall);
    end
    drive_req(1'b1, 1'b0, 3'd0, 32'd3, 32'd5, 5'd2);
    sb.push_back('{32'd15, 5'd2});
    #1;
    nvec++;
    if ({md_stall, md_ready} !== 2'b10) begin
      nerr++;
      $display("FAIL rst_busy_stall got stall=%b ready=%b exp stall=1 ready=0", md_stall, md_ready);
    end
    step();
    #1;
    nvec++;
    if (u_start !== 1'b1 || u_a !== 32'd3 || u_b !== 32'd5) begin
      nerr++;
      $display("FAIL rst_busy_reissue got start=%b a=%0d b=%0d exp 1 3 5", u_start, u_a, u_b);
    end
    wait_ready(10, n);
    nvec++;
    if (n != int'(MUL_LAT)) begin
      nerr++;
      $display("FAIL rst_busy_latency got %0d exp %0d", n, MUL_LAT);
    end
    step();
    drive_idle();
    #1;
  endtask

  task automatic test_both_class();
    int n;
    step();
    drive_req(1'b1, 1'b1, 3'd3, 32'd9, 32'd4, 5'd7);
    sb.push_back('{32'd36, 5'd7});
    #1;
    step();
    #1;
    nvec++;
    if (u_start !== 1'b1 || u_is_div !== 1'b0 || u_sel !== 3'd3) begin
      nerr++;
      $display("FAIL both_class got start=%b div=%b sel=%0d exp 1 0 3", u_start, u_is_div, u_sel);
    end
    wait_ready(50, n);
    nvec++;
    if (n != int'(MUL_LAT)) begin
      nerr++;
      $display("FAIL both_latency got %0d exp %0d", n, MUL_LAT);
    end
    step();
    drive_idle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_cache_hit();
    test_flush();
    test_stall_busy();
    test_reset_busy();
    test_both_class();
    step();
    step();
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Issue sequencer for the shared iterative multiply/divide datapath behind the decode stage. It accepts MUL/DIV instructions presented in decode, latches their operands, and pulses a start to the fixed-latency unit. It counts the unit latency, captures the result and produces the decode stall and ready signals used to hold the instruction in ID. A one-entry result cache lets an identical back-to-back MUL/DIV request complete without re-running the unit.

## Interface
- XLEN, 32, operand/result width
- MUL_CYCLES, 4, multiplier latency from start pulse to valid `u_result` (≥1)
- DIV_CYCLES, 33, divider latency from start pulse to valid `u_result` (≥1)
- clk  in  1  system clock; single clock domain
- Rst  in  1  synchronous, active-low reset
- stall_in  in  1  pipeline freeze (dbg | mem_hold | f_stall); blocks accept and consume
- flush  in  1  branch/trap kill of the instruction in decode
- req_valid  in  1  decode holds an instruction free of data hazards
- req_mul  in  1  instruction is MUL-class
- req_div  in  1  instruction is DIV-class; ignored when req_mul=1
- req_sel  in  3  funct3 operation select
- req_rs1, req_rs2  in  XLEN  forwarded operands
- req_rd  in  5  destination register
- u_start  out  1  one-cycle start pulse to the unit
- u_is_div  out  1  selects the divider (1) or the multiplier (0)
- u_sel  out  3  registered op select, held from start to capture
- u_a, u_b  out  XLEN  registered operands, held from start to capture
- u_result  in  XLEN  unit result, valid in the last counted cycle
- md_stall  out  1  combinational; OR'd into decode `hz`
- md_ready  out  1  result valid for the instruction in decode
- md_result  out  XLEN  captured result
- md_rd  out  5  destination register of the captured result

## Operation
- A request is MD-class when `req_valid & (req_mul | req_div)`. An accept occurs when the request is MD-class, `stall_in=0`, `flush=0` and the state is IDLE.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE, accept, cache miss: register sel, operands, rd and is_div. Load the counter with MUL_CYCLES or DIV_CYCLES. Next state is BUSY.
- IDLE, accept, cache hit: load `md_result` from the cache. Next state is DONE. `u_start` is not asserted.
- Cache hit condition: cache valid and {is_div, sel, rs1, rs2} all equal to the cached tag. `rd` is not part of the tag.
- BUSY: the counter decrements every cycle, independent of `stall_in`, because the unit cannot be frozen. When the counter is 1, capture `u_result` into `md_result` and into the cache, set cache valid and the tag, and move to DONE.
- DONE: when `req_valid` is high and `stall_in` is low, the instruction consumes the result and the state moves to IDLE.
- `md_stall = MD-class request & (state != DONE)`.
- `md_ready = (state == DONE)`.
- Flush in BUSY: abort and return to IDLE. The late `u_result` is ignored and the cache is unchanged.
- Flush in DONE: return to IDLE; the cache is kept.
- Flush in IDLE: no accept occurs.
- `req_*` changes while BUSY or DONE are ignored because all values are registered at accept.
- `req_mul` and `req_div` both high: treated as MUL.
- Reset (Rst=0 at an edge), including mid-operation:
  - state goes to IDLE and the counter to 0;
  - cache is invalidated;
  - `u_start`, `u_is_div`, `u_sel`, `u_a`, `u_b`, `md_result` and `md_rd` are all 0, so `md_ready` is 0.

## Timing
- Accept at cycle T.
  - Cache miss: `u_start`=1 in T+1 only. Capture at the end of T+LAT. `md_ready`=1 from T+LAT+1. `md_stall`=1 during T..T+LAT.
  - Cache hit: `md_ready`=1 at T+1; `md_stall`=1 for cycle T only.
- With MUL_CYCLES=4, a MUL stalls decode for 5 cycles.
- Earliest re-accept is the cycle after the consume cycle, when the state is IDLE.
- The counter width is clog2(max(MUL_CYCLES, DIV_CYCLES)+1).
- There is no combinational path from `u_result` to any output.
- Only `md_stall` is combinational from the `req_*` inputs.

## Test plan
- Reset, then MUL with rs1=7, rs2=6, sel=0, rd=5 → `u_start` at T+1 with `u_a`=7 and `u_b`=6; `md_stall` high for 5 cycles; `md_ready` at T+5 with `md_result`=42 and `md_rd`=5; IDLE at T+6.
- DIV with rs1=100, rs2=7, then an identical DIV with rd=9 → second request: no `u_start`, `md_ready` at T+1, `md_result`=14, `md_rd`=9.
- DIV accepted, then flush at T+10 → IDLE at T+11 with no ready pulse; the next identical DIV misses the cache and pulses `u_start`.
- `stall_in` held high from T+2 to T+40 during a DIV → the counter still runs and DONE is reached at T+34; the result is held until `stall_in` falls; `md_ready` stays 1 and consume happens in the first free cycle.
- Rst=0 asserted during BUSY at T+3 → next cycle all outputs are 0, `md_stall` follows the request only, and the repeated identical MUL re-issues `u_start`.
- req_mul=1 and req_div=1 with sel=3 → `u_is_div`=0 and the counter uses MUL_CYCLES.
